// File: rtl/load_store_unit.sv
// Load/store unit: one RV32I memory op at a time, byte-lane steering, load extraction, register write-back.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] sdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        done,
    output logic        misalign
);

    // state   | meaning
    // S_IDLE  | ready for a new op
    // S_REQ   | memory request held until mem_ack
    // S_WB    | one-cycle register-file write of load data
    // S_FAULT | one-cycle misalign pulse (trap build only)
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_rd;
    logic [31:0] r_ldata;

    logic        accept;
    logic        mis_in;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] ld_c;

    assign accept = in_valid && (state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
    assign mis_in = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    (funct3[1] && (addr[1:0] != 2'b00));
`else
    assign mis_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_sdata  <= 32'h0;
            r_rd     <= 5'd0;
            r_ldata  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        r_store  <= is_store;
                        r_funct3 <= funct3;
                        r_addr   <= addr;
                        r_sdata  <= sdata;
                        r_rd     <= rd;
                        state    <= mis_in ? S_FAULT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (r_store) begin
                            state <= S_IDLE;
                        end else begin
                            r_ldata <= ld_c;
                            state   <= S_WB;
                        end
                    end
                end
                S_WB:    state <= S_IDLE;
                S_FAULT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Half lanes use only addr[1] and words ignore addr[1:0], so the non-trap build force-aligns.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = r_sdata;
        case (r_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << r_addr[1:0];
                wdata_c = {4{r_sdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {r_addr[1], 1'b0};
                wdata_c = {2{r_sdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = r_sdata;
            end
        endcase
    end

    always_comb begin
        byte_c = mem_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   byte_c = mem_rdata[7:0];
            2'b01:   byte_c = mem_rdata[15:8];
            2'b10:   byte_c = mem_rdata[23:16];
            default: byte_c = mem_rdata[31:24];
        endcase
        half_c = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_c   = mem_rdata;
        case (r_funct3[1:0])
            2'b00:   ld_c = r_funct3[2] ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
            2'b01:   ld_c = r_funct3[2] ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
            default: ld_c = mem_rdata;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req && r_store;
    assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be_c : 4'b0000;
    assign mem_wdata = mem_req ? wdata_c : 32'h0;

    assign WE3 = (state == S_WB) && (r_rd != 5'd0);
    assign A3  = (state == S_WB) ? r_rd : 5'd0;
    assign WD3 = (state == S_WB) ? r_ldata : 32'h0;

    assign done = (mem_req && mem_ack && r_store) || (state == S_WB);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (state == S_FAULT);
`else
    assign misalign = 1'b0;
`endif

endmodule
